// File: rtl/fft_bitrev_reorder_if.sv
// Sample stream bundle for the bit-reversed to natural-order reorder stage.
// Defining FFT_REORDER_IDX_EN adds the do_idx natural-index output.
interface fft_bitrev_reorder_if #(
    parameter int unsigned DATA_WIDTH = 16
`ifdef FFT_REORDER_IDX_EN
    ,
    parameter int unsigned LOG2N = 4
`endif
);
    logic                  di_en;
    logic [DATA_WIDTH-1:0] di_re;
    logic [DATA_WIDTH-1:0] di_im;
    logic                  do_en;
    logic [DATA_WIDTH-1:0] do_re;
    logic [DATA_WIDTH-1:0] do_im;
    logic                  do_last;
`ifdef FFT_REORDER_IDX_EN
    logic [LOG2N-1:0]      do_idx;

    modport master (
        output di_en, di_re, di_im,
        input  do_en, do_re, do_im, do_last, do_idx
    );

    modport slave (
        input  di_en, di_re, di_im,
        output do_en, do_re, do_im, do_last, do_idx
    );
`else
    modport master (
        output di_en, di_re, di_im,
        input  do_en, do_re, do_im, do_last
    );

    modport slave (
        input  di_en, di_re, di_im,
        output do_en, do_re, do_im, do_last
    );
`endif
endinterface

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer: frames arrive in bit-reversed order and leave in natural order.
// Optional FFT_REORDER_IDX_EN adds a registered do_idx output with the natural index.
module fft_bitrev_reorder #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned LOG2N      = 4
) (
    input logic               clk,
    input logic               rstn,
    fft_bitrev_reorder_if.slave bus
);
    localparam int unsigned N      = 1 << LOG2N;
    localparam int unsigned WORD_W = 2 * DATA_WIDTH;

    localparam logic StIdle  = 1'b0;
    localparam logic StDrain = 1'b1;

    localparam logic [LOG2N-1:0] CNT_MAX = {LOG2N{1'b1}};

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) begin
            r[i] = a[LOG2N-1-i];
        end
        return r;
    endfunction

    logic [WORD_W-1:0] mem_q [2*N];

    logic [LOG2N-1:0]      wr_cnt_q, wr_cnt_d;
    logic                  wr_bank_q, wr_bank_d;
    logic [1:0]            full_q, full_d;
    logic                  state_q, state_d;
    logic                  rd_bank_q, rd_bank_d;
    logic [LOG2N-1:0]      rd_cnt_q, rd_cnt_d;
    logic                  do_en_q, do_en_d;
    logic [DATA_WIDTH-1:0] do_re_q, do_re_d;
    logic [DATA_WIDTH-1:0] do_im_q, do_im_d;
    logic                  do_last_q, do_last_d;
`ifdef FFT_REORDER_IDX_EN
    logic [LOG2N-1:0]      do_idx_q, do_idx_d;
`endif

    logic              wr_fire;
    logic              wr_frame_done;
    logic [LOG2N:0]    wr_addr;
    logic [WORD_W-1:0] wr_data;
    logic              rd_fire;
    logic              rd_frame_done;
    logic              other_ready;
    logic [WORD_W-1:0] rd_word;

    // Write side: bit-reversed placement turns the natural-order replay into a linear read.
    always_comb begin
        wr_fire       = bus.di_en;
        wr_frame_done = wr_fire && (wr_cnt_q == CNT_MAX);
        wr_addr       = {wr_bank_q, bitrev(wr_cnt_q)};
        wr_data       = {bus.di_re, bus.di_im};
        wr_cnt_d      = wr_fire ? wr_cnt_q + LOG2N'(1) : wr_cnt_q;
        wr_bank_d     = wr_frame_done ? ~wr_bank_q : wr_bank_q;
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_fire       = (state_q == StDrain);
        rd_frame_done = rd_fire && (rd_cnt_q == CNT_MAX);
        rd_word       = mem_q[{rd_bank_q, rd_cnt_q}];
        // A frame completing on the other bank this very edge still counts as ready.
        other_ready   = full_q[~rd_bank_q] || (wr_frame_done && (wr_bank_q == ~rd_bank_q));

        full_d = full_q;
        if (rd_frame_done) begin
            full_d[rd_bank_q] = 1'b0;
        end
        if (wr_frame_done) begin
            full_d[wr_bank_q] = 1'b1;
        end
    end

    // Read engine; rd_bank always points at the oldest undrained bank.
    always_comb begin
        state_d   = state_q;
        rd_bank_d = rd_bank_q;
        rd_cnt_d  = rd_cnt_q;
        case (state_q)
            StIdle: begin
                rd_cnt_d = '0;
                if (full_q[rd_bank_q]) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                rd_cnt_d = rd_cnt_q + LOG2N'(1);
                if (rd_frame_done) begin
                    rd_bank_d = ~rd_bank_q;
                    rd_cnt_d  = '0;
                    if (!other_ready) begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        do_en_d   = rd_fire;
        do_last_d = rd_frame_done;
        do_re_d   = do_re_q;
        do_im_d   = do_im_q;
`ifdef FFT_REORDER_IDX_EN
        do_idx_d  = do_idx_q;
`endif
        if (rd_fire) begin
            do_re_d  = rd_word[WORD_W-1:DATA_WIDTH];
            do_im_d  = rd_word[DATA_WIDTH-1:0];
`ifdef FFT_REORDER_IDX_EN
            do_idx_d = rd_cnt_q;
`endif
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_cnt_q  <= '0;
            wr_bank_q <= 1'b0;
            full_q    <= 2'b00;
            state_q   <= StIdle;
            rd_bank_q <= 1'b0;
            rd_cnt_q  <= '0;
            do_en_q   <= 1'b0;
            do_re_q   <= '0;
            do_im_q   <= '0;
            do_last_q <= 1'b0;
`ifdef FFT_REORDER_IDX_EN
            do_idx_q  <= '0;
`endif
        end else begin
            wr_cnt_q  <= wr_cnt_d;
            wr_bank_q <= wr_bank_d;
            full_q    <= full_d;
            state_q   <= state_d;
            rd_bank_q <= rd_bank_d;
            rd_cnt_q  <= rd_cnt_d;
            do_en_q   <= do_en_d;
            do_re_q   <= do_re_d;
            do_im_q   <= do_im_d;
            do_last_q <= do_last_d;
`ifdef FFT_REORDER_IDX_EN
            do_idx_q  <= do_idx_d;
`endif
        end
    end

    assign bus.do_en   = do_en_q;
    assign bus.do_re   = do_re_q;
    assign bus.do_im   = do_im_q;
    assign bus.do_last = do_last_q;
`ifdef FFT_REORDER_IDX_EN
    assign bus.do_idx  = do_idx_q;
`endif

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Randomized bench for fft_bitrev_reorder against a frame-level reorder model.
// With FFT_REORDER_IDX_EN defined the bench uses N=8 and also checks do_idx.
`timescale 1ns/1ps
module tb_fft_bitrev_reorder;
    localparam int unsigned DATA_WIDTH = 16;
`ifdef FFT_REORDER_IDX_EN
    localparam int unsigned LOG2N = 3;
`else
    localparam int unsigned LOG2N = 4;
`endif
    localparam int N = 1 << LOG2N;

    typedef struct {
        logic [DATA_WIDTH-1:0] re;
        logic [DATA_WIDTH-1:0] im;
        logic                  last;
        logic [LOG2N-1:0]      idx;
        int                    cyc;
    } cap_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   cyc  = 0;
    int   errors = 0;
    int   checks = 0;
    int   stray_last = 0;

    cap_t                  cap_q[$];
    cap_t                  exp_q[$];
    logic [DATA_WIDTH-1:0] stim_re[$];
    logic [DATA_WIDTH-1:0] stim_im[$];

    fft_bitrev_reorder_if #(
        .DATA_WIDTH(DATA_WIDTH)
`ifdef FFT_REORDER_IDX_EN
        ,
        .LOG2N(LOG2N)
`endif
    ) bus ();

    fft_bitrev_reorder #(
        .DATA_WIDTH(DATA_WIDTH),
        .LOG2N     (LOG2N)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.do_en === 1'b1) begin
            cap_t c;
            c.re   = bus.do_re;
            c.im   = bus.do_im;
            c.last = bus.do_last;
`ifdef FFT_REORDER_IDX_EN
            c.idx  = bus.do_idx;
`else
            c.idx  = '0;
`endif
            c.cyc  = cyc;
            cap_q.push_back(c);
        end else if (bus.do_last !== 1'b0) begin
            stray_last++;
        end
    end

    function automatic int brev(input int x);
        int r = 0;
        for (int i = 0; i < LOG2N; i++) begin
            r = r * 2 + x % 2;
            x = x / 2;
        end
        return r;
    endfunction

    // Natural output j of a frame is the sample that arrived at position brev(j).
    task automatic build_expected(input int nframes);
        exp_q.delete();
        for (int f = 0; f < nframes; f++) begin
            for (int j = 0; j < N; j++) begin
                cap_t e;
                e.re   = stim_re[f * N + brev(j)];
                e.im   = stim_im[f * N + brev(j)];
                e.last = (j == N - 1);
`ifdef FFT_REORDER_IDX_EN
                e.idx  = LOG2N'(j);
`else
                e.idx  = '0;
`endif
                e.cyc  = 0;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic drive(input logic en, input logic [DATA_WIDTH-1:0] re,
                         input logic [DATA_WIDTH-1:0] im);
        @(negedge clk);
        bus.di_en = en;
        bus.di_re = re;
        bus.di_im = im;
    endtask

    task automatic send_stim(input int gap_pct, output int last_cyc);
        last_cyc = 0;
        for (int k = 0; k < stim_re.size(); k++) begin
            for (int g = 0; g < 8 && int'($urandom_range(99)) < gap_pct; g++) begin
                drive(1'b0, '0, '0);
            end
            drive(1'b1, stim_re[k], stim_im[k]);
            last_cyc = cyc;
        end
        drive(1'b0, '0, '0);
    endtask

    task automatic wait_out(input int n, output bit ok);
        for (int t = 0; t < 64 * N && cap_q.size() < n; t++) @(posedge clk);
        repeat (N + 4) @(posedge clk);
        ok = (cap_q.size() >= n);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        bus.di_en = 1'b0;
        bus.di_re = '0;
        bus.di_im = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.do_en !== 1'b0 || bus.do_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl got en=%b last=%b required 0 0", bus.do_en, bus.do_last);
        end
        checks++;
        if (bus.do_re !== '0 || bus.do_im !== '0) begin
            errors++;
            $display("FAIL reset_data got re=%h im=%h required 0 0", bus.do_re, bus.do_im);
        end
`ifdef FFT_REORDER_IDX_EN
        checks++;
        if (bus.do_idx !== '0) begin
            errors++;
            $display("FAIL reset_idx got %0d required 0", bus.do_idx);
        end
`endif
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_frame();
        int  last_cyc;
        bit  ok;
        cap_q.delete();
        stim_re.delete();
        stim_im.delete();
        for (int k = 0; k < N; k++) begin
            stim_re.push_back(DATA_WIDTH'(brev(k)));
            stim_im.push_back('0);
        end
        build_expected(1);
        send_stim(0, last_cyc);
        wait_out(N, ok);
        checks++;
        if (!ok || cap_q.size() != N) begin
            errors++;
            $display("FAIL single_count got %0d required %0d", cap_q.size(), N);
        end
        for (int i = 0; i < N && i < cap_q.size(); i++) begin
            checks++;
            if (cap_q[i].re !== DATA_WIDTH'(i) || cap_q[i].im !== exp_q[i].im ||
                cap_q[i].last !== exp_q[i].last || cap_q[i].idx !== exp_q[i].idx) begin
                errors++;
                $display("FAIL single_data[%0d] got re=%h im=%h last=%b idx=%0d required re=%h im=%h last=%b idx=%0d",
                         i, cap_q[i].re, cap_q[i].im, cap_q[i].last, cap_q[i].idx,
                         exp_q[i].re, exp_q[i].im, exp_q[i].last, exp_q[i].idx);
            end
        end
        if (cap_q.size() > 0) begin
            checks++;
            if (cap_q[0].cyc != last_cyc + 3) begin
                errors++;
                $display("FAIL single_latency got cycle %0d required %0d", cap_q[0].cyc, last_cyc + 3);
            end
            checks++;
            if (cap_q[cap_q.size()-1].cyc - cap_q[0].cyc != cap_q.size() - 1) begin
                errors++;
                $display("FAIL single_contiguous got span %0d required %0d",
                         cap_q[cap_q.size()-1].cyc - cap_q[0].cyc, cap_q.size() - 1);
            end
        end
    endtask

    task automatic test_back_to_back();
        int last_cyc;
        bit ok;
        cap_q.delete();
        stim_re.delete();
        stim_im.delete();
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < N; k++) begin
                stim_re.push_back(DATA_WIDTH'(brev(k) + N * f));
                stim_im.push_back(DATA_WIDTH'($urandom));
            end
        end
        build_expected(3);
        send_stim(0, last_cyc);
        wait_out(3 * N, ok);
        checks++;
        if (!ok || cap_q.size() != 3 * N) begin
            errors++;
            $display("FAIL b2b_count got %0d required %0d", cap_q.size(), 3 * N);
        end
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            checks++;
            if (cap_q[i].re !== exp_q[i].re || cap_q[i].im !== exp_q[i].im ||
                cap_q[i].last !== exp_q[i].last || cap_q[i].idx !== exp_q[i].idx) begin
                errors++;
                $display("FAIL b2b_data[%0d] got re=%h im=%h last=%b idx=%0d required re=%h im=%h last=%b idx=%0d",
                         i, cap_q[i].re, cap_q[i].im, cap_q[i].last, cap_q[i].idx,
                         exp_q[i].re, exp_q[i].im, exp_q[i].last, exp_q[i].idx);
            end
        end
        if (cap_q.size() > 0) begin
            checks++;
            if (cap_q[cap_q.size()-1].cyc - cap_q[0].cyc != cap_q.size() - 1) begin
                errors++;
                $display("FAIL b2b_contiguous got span %0d required %0d",
                         cap_q[cap_q.size()-1].cyc - cap_q[0].cyc, cap_q.size() - 1);
            end
        end
    endtask

    task automatic test_gaps();
        int last_cyc;
        bit ok;
        cap_q.delete();
        stim_re.delete();
        stim_im.delete();
        for (int k = 0; k < N; k++) begin
            stim_re.push_back(DATA_WIDTH'(brev(k)));
            stim_im.push_back(DATA_WIDTH'(0) - DATA_WIDTH'(brev(k)));
        end
        for (int k = 0; k < N; k++) begin
            stim_re.push_back(DATA_WIDTH'($urandom));
            stim_im.push_back(DATA_WIDTH'($urandom));
        end
        build_expected(2);
        send_stim(50, last_cyc);
        wait_out(2 * N, ok);
        checks++;
        if (!ok || cap_q.size() != 2 * N) begin
            errors++;
            $display("FAIL gaps_count got %0d required %0d", cap_q.size(), 2 * N);
        end
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            checks++;
            if (cap_q[i].re !== exp_q[i].re || cap_q[i].im !== exp_q[i].im ||
                cap_q[i].last !== exp_q[i].last || cap_q[i].idx !== exp_q[i].idx) begin
                errors++;
                $display("FAIL gaps_data[%0d] got re=%h im=%h last=%b idx=%0d required re=%h im=%h last=%b idx=%0d",
                         i, cap_q[i].re, cap_q[i].im, cap_q[i].last, cap_q[i].idx,
                         exp_q[i].re, exp_q[i].im, exp_q[i].last, exp_q[i].idx);
            end
        end
    endtask

    task automatic test_reset_mid();
        int last_cyc;
        bit ok;
        cap_q.delete();
        // Partial frame, then reset: none of it may ever appear.
        for (int k = 0; k < 7; k++) begin
            drive(1'b1, DATA_WIDTH'($urandom), DATA_WIDTH'($urandom));
        end
        drive(1'b0, '0, '0);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        stim_re.delete();
        stim_im.delete();
        for (int k = 0; k < N; k++) begin
            stim_re.push_back(DATA_WIDTH'($urandom));
            stim_im.push_back(DATA_WIDTH'($urandom));
        end
        build_expected(1);
        send_stim(0, last_cyc);
        wait_out(N, ok);
        checks++;
        if (!ok || cap_q.size() != N) begin
            errors++;
            $display("FAIL rst_partial_count got %0d required %0d", cap_q.size(), N);
        end
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            checks++;
            if (cap_q[i].re !== exp_q[i].re || cap_q[i].im !== exp_q[i].im ||
                cap_q[i].last !== exp_q[i].last || cap_q[i].idx !== exp_q[i].idx) begin
                errors++;
                $display("FAIL rst_partial_data[%0d] got re=%h im=%h required re=%h im=%h",
                         i, cap_q[i].re, cap_q[i].im, exp_q[i].re, exp_q[i].im);
            end
        end
        // Reset in the middle of a drain clears outputs at once and discards the rest.
        cap_q.delete();
        send_stim(0, last_cyc);
        for (int t = 0; t < 16 * N && cap_q.size() < 3; t++) @(posedge clk);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        checks++;
        if (bus.do_en !== 1'b0 || bus.do_last !== 1'b0 || bus.do_re !== '0 || bus.do_im !== '0) begin
            errors++;
            $display("FAIL rst_drain_outputs got en=%b last=%b re=%h im=%h required all 0",
                     bus.do_en, bus.do_last, bus.do_re, bus.do_im);
        end
        @(negedge clk);
        rstn = 1'b1;
        ok = (cap_q.size() >= 3);
        repeat (2 * N) @(negedge clk);
        checks++;
        if (!ok || cap_q.size() > N - 1) begin
            errors++;
            $display("FAIL rst_drain_discard got %0d outputs required between 3 and %0d",
                     cap_q.size(), N - 1);
        end
    endtask

    task automatic test_full_scale();
        int last_cyc;
        bit ok;
        cap_q.delete();
        stim_re.delete();
        stim_im.delete();
        for (int k = 0; k < N; k++) begin
            stim_re.push_back((k % 2 == 0) ? 16'h7FFF : 16'h8000);
            stim_im.push_back((k % 2 == 0) ? 16'h8000 : 16'h7FFF);
        end
        build_expected(1);
        send_stim(30, last_cyc);
        wait_out(N, ok);
        checks++;
        if (!ok || cap_q.size() != N) begin
            errors++;
            $display("FAIL full_scale_count got %0d required %0d", cap_q.size(), N);
        end
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            checks++;
            if (cap_q[i].re !== exp_q[i].re || cap_q[i].im !== exp_q[i].im ||
                cap_q[i].last !== exp_q[i].last || cap_q[i].idx !== exp_q[i].idx) begin
                errors++;
                $display("FAIL full_scale_data[%0d] got re=%h im=%h required re=%h im=%h",
                         i, cap_q[i].re, cap_q[i].im, exp_q[i].re, exp_q[i].im);
            end
        end
    endtask

    task automatic test_stray_last();
        checks++;
        if (stray_last != 0) begin
            errors++;
            $display("FAIL stray_last got %0d cycles with do_last and no do_en required 0", stray_last);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_gaps();
        test_reset_mid();
        test_full_scale();
        test_stray_last();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
